victim_cache_ctrl: RTL
======================

Name: victim_cache_ctrl

Overview:
- Sequencing and replacement controller for the 8-entry fully associative victim cache data array.
- Owns the tag/valid array (ptag plus set index), arbitrates L1 miss lookups against L1 eviction inserts, and runs the TL/TV lookup pipeline, where the physical tag arrives one cycle late.
- Drives way select and write strobe to the data array; data bytes bypass this block.

Parameters:
NUM_WAYS, 8, victim entries (power of 2, >=2)
PTAG_W, 44, physical tag width from TLB
IDX_W, 6, line index width (addr bits [11:6])
STARVE_LIM, 4, consecutive blocked cycles before a pending eviction beats a lookup

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
lk_valid  in  1  lookup request (L1 miss)
lk_ready  out  1  lookup accepted when lk_valid && lk_ready
lk_addr  in  12  untranslated vaddr bits; [11:6] index, [5:0] byte offset
phys_tag_ret  in  PTAG_W  ptag for accepted lookup, valid the cycle after accept
tlb_miss  in  1  TLB miss, same cycle as phys_tag_ret
ev_valid  in  1  L1 eviction insert request
ev_ready  out  1  eviction accepted when ev_valid && ev_ready
ev_ptag  in  PTAG_W  evicted line ptag
ev_index  in  IDX_W  evicted line index
dat_we  out  1  data array write strobe (eviction install)
dat_way  out  $clog2(NUM_WAYS)  way for dat_we or read
rsp_valid  out  1  one-cycle lookup result pulse
rsp_hit  out  1  hit qualifier
rsp_tlb_miss  out  1  lookup aborted by TLB miss
rsp_way  out  $clog2(NUM_WAYS)  hit way (0 on miss)
rsp_offset  out  6  byte offset of the answered lookup
hit_cnt  out  32  perf counter (see optional feature)
miss_cnt  out  32  perf counter (see optional feature)

Behaviour:
- Reset values: all valid bits 0, rr_ptr 0, starve count 0, state IDLE.
- Outputs in reset cycle: lk_ready, ev_ready, dat_we, rsp_* and counters all 0.
- Reset mid-lookup discards it; no rsp_valid is produced.
- States:
  - IDLE: lk_ready=1. A lookup fire captures index/offset and moves to TV.
  - TV: samples phys_tag_ret/tlb_miss, compares {ptag,index} against all valid ways, registers the result, moves to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Latency: accept at T, tag at T+1, rsp_valid at T+2. Minimum lookup spacing is 3 cycles.
- Hit: rsp_hit=1, rsp_way=matching way. The entry valid clears at the TV->RESP edge (line swaps back to L1).
- Miss: rsp_hit=0, rsp_way=0.
- tlb_miss=1 in TV: rsp_hit=0, rsp_tlb_miss=1, no valid change, no counter change. ptag is ignored.
- Eviction and ev_ready:
  - ev_ready = (state==IDLE) && (!lk_valid || starve>=STARVE_LIM). Combinational.
  - Starve count increments each IDLE cycle with ev_valid && lk_valid && !ev_ready. It saturates at STARVE_LIM and clears on an eviction fire.
  - When starve>=STARVE_LIM and both requesters are valid, the eviction wins and lk_ready=0 that cycle. Otherwise the lookup wins.
- Eviction fire: dat_we=1 in the same cycle, with dat_way the chosen way. Tag/valid update at the edge.
- Way choice, in priority order:
  1. Way already holding {ev_ptag,ev_index} (no duplicate entries).
  2. Otherwise the lowest-index invalid way.
  3. Otherwise rr_ptr; rr_ptr then increments mod NUM_WAYS.
  - rr_ptr advances only on case 3.
- During TV/RESP, dat_way = captured hit way; dat_we=0.
- Evictions are never accepted in TV/RESP, so there is no tag-array read/write hazard.
- Tag match uses {PTAG_W+IDX_W} bits exactly and is qualified by the valid bit.

Optional Feature:
VC_PERF_CNT_EN:
- Defined: hit_cnt and miss_cnt increment on rsp_valid with hit or miss respectively. TLB-miss responses are excluded. Counters wrap at 2^32 and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then lookup addr 0x040 with ptag 0x1 -> rsp_valid at T+2, rsp_hit=0, rsp_offset=0; miss_cnt=1 if enabled.
- Evict ptag 0xABC, index 5; then lookup addr 0x14A with ptag 0xABC -> dat_we, way 0 at evict; rsp_hit=1, way 0, offset 0x0A. Repeat lookup -> miss (entry invalidated).
- Fill 8 distinct lines, then a 9th and 10th -> ways 0..7 used, 9th to way 0, 10th to way 1. Re-evict line in way 3 -> way 3, rr_ptr unchanged.
- Hold lk_valid and ev_valid high continuously -> lookup first. Eviction accepted in an IDLE cycle once starve reaches 4; lk_ready=0 that cycle.
- Lookup with tlb_miss=1 at T+1 -> rsp_tlb_miss=1, rsp_hit=0, valid bits and counters unchanged.
- Assert reset during TV -> no rsp_valid, lk_ready=1 the cycle after reset drops, all ways invalid.

Source files
------------

// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl: sequencing and replacement controller for the fully associative
// victim cache. It owns the tag/valid array and arbitrates L1 miss lookups against
// L1 eviction inserts. It also runs the TL/TV lookup pipeline, in which the physical
// tag arrives one cycle after the lookup is accepted. Data bytes do not pass through
// this block; it only drives way select and the write strobe.
//
// Optional feature: define VC_PERF_CNT_EN to build the hit/miss performance counters.
// When it is undefined, hit_cnt and miss_cnt are tied to 0.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   lk_valid/ready    lookup handshake; lk_addr[11:6] index, lk_addr[5:0] byte offset
//   phys_tag_ret      ptag for the accepted lookup, valid the cycle after accept
//   tlb_miss          TLB miss, same cycle as phys_tag_ret
//   ev_valid/ready    eviction insert handshake, with ev_ptag and ev_index
//   dat_we, dat_way   data array write strobe and way select
//   rsp_*             one-cycle lookup result (valid, hit, tlb_miss, way, offset)
//   hit_cnt, miss_cnt performance counters
module victim_cache_ctrl #(
  parameter int unsigned NUM_WAYS   = 8,
  parameter int unsigned PTAG_W     = 44,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        lk_valid,
  output logic                        lk_ready,
  input  logic [11:0]                 lk_addr,
  input  logic [PTAG_W-1:0]           phys_tag_ret,
  input  logic                        tlb_miss,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic [PTAG_W-1:0]           ev_ptag,
  input  logic [IDX_W-1:0]            ev_index,
  output logic                        dat_we,
  output logic [$clog2(NUM_WAYS)-1:0] dat_way,
  output logic                        rsp_valid,
  output logic                        rsp_hit,
  output logic                        rsp_tlb_miss,
  output logic [$clog2(NUM_WAYS)-1:0] rsp_way,
  output logic [5:0]                  rsp_offset,
  output logic [31:0]                 hit_cnt,
  output logic [31:0]                 miss_cnt
);

  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned TAG_W = PTAG_W + IDX_W;
  localparam int unsigned SW    = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIM);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StTv   = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [NUM_WAYS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q [NUM_WAYS];
  logic [WAY_W-1:0]    rr_q;
  logic [SW-1:0]       starve_q;
  logic [IDX_W-1:0]    idx_q;
  logic [5:0]          off_q;
  logic                rsp_hit_q, rsp_tlb_q;
  logic [WAY_W-1:0]    way_q;

  logic idle, starve_at_lim, lk_fire, ev_fire;

  assign idle          = (state_q == StIdle);
  assign starve_at_lim = (starve_q >= StarveMax);

  // A starved eviction takes the IDLE slot away from a waiting lookup.
  assign ev_ready = idle && !reset && (!lk_valid || starve_at_lim);
  assign lk_ready = idle && !reset && !(lk_valid && ev_valid && starve_at_lim);
  assign lk_fire  = lk_valid && lk_ready;
  assign ev_fire  = ev_valid && ev_ready;

  // Eviction way choice: an existing copy, else the lowest free way, else round robin.
  logic             ev_dup_found, ev_free_found, ev_use_rr;
  logic [WAY_W-1:0] ev_dup_way, ev_free_way, ev_way;

  always_comb begin
    ev_dup_found  = 1'b0;
    ev_dup_way    = '0;
    ev_free_found = 1'b0;
    ev_free_way   = '0;
    // Walk downwards so the lowest matching index is the last one assigned.
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (valid_q[w] && (tag_q[w] == {ev_ptag, ev_index})) begin
        ev_dup_found = 1'b1;
        ev_dup_way   = WAY_W'(w);
      end
      if (!valid_q[w]) begin
        ev_free_found = 1'b1;
        ev_free_way   = WAY_W'(w);
      end
    end
    ev_use_rr = !ev_dup_found && !ev_free_found;
    ev_way    = ev_dup_found ? ev_dup_way : (ev_free_found ? ev_free_way : rr_q);
  end

  // TV-stage tag compare; duplicates are never installed, so at most one way matches.
  logic             tv_any, tv_hit;
  logic [WAY_W-1:0] tv_way;

  always_comb begin
    tv_any = 1'b0;
    tv_way = '0;
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (valid_q[w] && (tag_q[w] == {phys_tag_ret, idx_q})) begin
        tv_any = 1'b1;
        tv_way = WAY_W'(w);
      end
    end
    tv_hit = tv_any && !tlb_miss;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (lk_fire) state_d = StTv;
      StTv:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      valid_q   <= '0;
      rr_q      <= '0;
      starve_q  <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      rsp_hit_q <= 1'b0;
      rsp_tlb_q <= 1'b0;
      way_q     <= '0;
    end else begin
      state_q <= state_d;
      if (lk_fire) begin
        idx_q <= lk_addr[11:6];
        off_q <= lk_addr[5:0];
      end
      if (state_q == StTv) begin
        rsp_hit_q <= tv_hit;
        rsp_tlb_q <= tlb_miss;
        way_q     <= tv_hit ? tv_way : '0;
        // A hit line swaps back into L1, so the victim copy is dropped.
        if (tv_hit) valid_q[tv_way] <= 1'b0;
      end
      if (ev_fire) begin
        valid_q[ev_way] <= 1'b1;
        starve_q        <= '0;
        if (ev_use_rr) rr_q <= rr_q + 1'b1;
      end else if (idle && ev_valid && lk_valid && !ev_ready && !starve_at_lim) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  // Tag storage needs no reset; entries are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (ev_fire) tag_q[ev_way] <= {ev_ptag, ev_index};
  end

  assign dat_we  = ev_fire;
  assign dat_way = idle ? ev_way : way_q;

  assign rsp_valid    = (state_q == StResp) && !reset;
  assign rsp_hit      = rsp_valid && rsp_hit_q;
  assign rsp_tlb_miss = rsp_valid && rsp_tlb_q;
  assign rsp_way      = rsp_valid ? way_q : '0;
  assign rsp_offset   = rsp_valid ? off_q : '0;

`ifdef VC_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StResp && !rsp_tlb_q) begin
      if (rsp_hit_q) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else           miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = reset ? '0 : hit_cnt_q;
  assign miss_cnt = reset ? '0 : miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
